// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet layer blocks.
//   - am_state_e : argmax stage FSM states
//   - DATA_WIDTH_DEF / ADDR_WIDTH_DEF : default DRAM word and address widths
//   - class_idx_w() : width of a class index for a given class count
package lenet_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 18;

  typedef enum logic [2:0] {
    AM_IDLE,
    AM_RD_REQ,
    AM_RD_WAIT,
    AM_WR_IDX,
    AM_WR_VAL,
    AM_DONE
  } am_state_e;

  // $clog2(N_CLASS), kept at least 1 bit wide.
  function automatic int unsigned class_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lenet_argmax_trk.sv
// Running-maximum tracker for the argmax stage.
// Ports:
//   clk, srstn  clock, asynchronous active-low reset
//   clear       restart tracking (next loaded word is taken unconditionally)
//   load        a score word is present on data_in for class index idx
//   data_in     signed score
//   idx         class index of data_in
//   best_val    current maximum score
//   best_idx    class index of best_val (lowest index on ties)
module lenet_argmax_trk #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  clear,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [IDX_W-1:0]      idx,
  output logic [DATA_WIDTH-1:0] best_val,
  output logic [IDX_W-1:0]      best_idx
);

  logic first;
  logic take;

  // Strict greater-than: an equal score never displaces the earlier index.
  assign take = load && (first || ($signed(data_in) > $signed(best_val)));

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      best_val <= '0;
      best_idx <= '0;
      first    <= 1'b1;
    end else if (clear) begin
      best_val <= '0;
      best_idx <= '0;
      first    <= 1'b1;
    end else if (take) begin
      best_val <= data_in;
      best_idx <= idx;
      first    <= 1'b0;
    end
  end

endmodule

// File: rtl/lenet_argmax.sv
// Final LeNet classification stage: reads N_CLASS signed FC scores from DRAM
// (one outstanding read), tracks the maximum and writes the winning class
// index to DST_BASE, then pulses done for one cycle.
// Optional macro ARGMAX_WR_SCORE_EN: additionally writes the winning score to
// DST_BASE+1 after the index (done arrives one cycle later).
// Ports:
//   clk, srstn  clock, asynchronous active-low reset
//   enable      stage enable (level); pauses request/write states when low
//   dram_valid  data_in holds the word for the pending read
//   data_in     DRAM read data
//   data_out    DRAM write data (0 when dram_en_wr is 0)
//   addr_in     DRAM read address (0 when dram_en_rd is 0)
//   addr_out    DRAM write address (0 when dram_en_wr is 0)
//   dram_en_rd  read strobe, one cycle per word
//   dram_en_wr  write strobe, one cycle per word
//   done        one-cycle pulse after the result write
module lenet_argmax
  import lenet_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned            ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned            N_CLASS    = 10,
  parameter logic [ADDR_WIDTH-1:0]  SRC_BASE   = ADDR_WIDTH'('h0),
  parameter logic [ADDR_WIDTH-1:0]  DST_BASE   = ADDR_WIDTH'('h10)
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  enable,
  input  logic                  dram_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  dram_en_rd,
  output logic                  dram_en_wr,
  output logic                  done
);

  localparam int unsigned IDX_W = class_idx_w(N_CLASS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASS - 1);

  am_state_e             state, state_nx;
  logic [IDX_W-1:0]      idx_cnt, idx_cnt_nx;

  logic                  rd_nx, wr_nx, done_nx;
  logic [ADDR_WIDTH-1:0] addr_in_nx, addr_out_nx;
  logic [DATA_WIDTH-1:0] data_out_nx;

  logic                  trk_clear, trk_load;
  logic [DATA_WIDTH-1:0] best_val;
  logic [IDX_W-1:0]      best_idx;

  lenet_argmax_trk #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_trk (
    .clk      (clk),
    .srstn    (srstn),
    .clear    (trk_clear),
    .load     (trk_load),
    .data_in  (data_in),
    .idx      (idx_cnt),
    .best_val (best_val),
    .best_idx (best_idx)
  );

`ifndef ARGMAX_WR_SCORE_EN
  logic unused_best_val;
  assign unused_best_val = ^best_val;
`endif

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state   <= AM_IDLE;
      idx_cnt <= '0;
    end else begin
      state   <= state_nx;
      idx_cnt <= idx_cnt_nx;
    end
  end

  // Next-state and next-value of the registered DRAM port signals; every
  // address/data value is forced to 0 unless its strobe is set this cycle.
  always_comb begin
    state_nx    = state;
    idx_cnt_nx  = idx_cnt;
    rd_nx       = 1'b0;
    wr_nx       = 1'b0;
    done_nx     = 1'b0;
    addr_in_nx  = '0;
    addr_out_nx = '0;
    data_out_nx = '0;
    trk_clear   = 1'b0;
    trk_load    = 1'b0;

    case (state)
      AM_IDLE: begin
        if (enable) begin
          idx_cnt_nx = '0;
          trk_clear  = 1'b1;
          state_nx   = AM_RD_REQ;
        end
      end
      AM_RD_REQ: begin
        if (enable) begin
          rd_nx      = 1'b1;
          addr_in_nx = SRC_BASE + ADDR_WIDTH'(idx_cnt);
          state_nx   = AM_RD_WAIT;
        end
      end
      AM_RD_WAIT: begin
        // The pending read completes regardless of enable.
        if (dram_valid) begin
          trk_load = 1'b1;
          if (idx_cnt == LAST_IDX) begin
            state_nx = AM_WR_IDX;
          end else begin
            idx_cnt_nx = idx_cnt + 1'b1;
            state_nx   = AM_RD_REQ;
          end
        end
      end
      AM_WR_IDX: begin
        if (enable) begin
          wr_nx       = 1'b1;
          addr_out_nx = DST_BASE;
          data_out_nx = DATA_WIDTH'(best_idx);
`ifdef ARGMAX_WR_SCORE_EN
          state_nx    = AM_WR_VAL;
`else
          state_nx    = AM_DONE;
`endif
        end
      end
      AM_WR_VAL: begin
`ifdef ARGMAX_WR_SCORE_EN
        if (enable) begin
          wr_nx       = 1'b1;
          addr_out_nx = DST_BASE + ADDR_WIDTH'(1);
          data_out_nx = best_val;
          state_nx    = AM_DONE;
        end
`else
        state_nx = AM_IDLE;
`endif
      end
      AM_DONE: begin
        done_nx  = 1'b1;
        state_nx = AM_IDLE;
      end
      default: state_nx = AM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      dram_en_rd <= 1'b0;
      dram_en_wr <= 1'b0;
      done       <= 1'b0;
      addr_in    <= '0;
      addr_out   <= '0;
      data_out   <= '0;
    end else begin
      dram_en_rd <= rd_nx;
      dram_en_wr <= wr_nx;
      done       <= done_nx;
      addr_in    <= addr_in_nx;
      addr_out   <= addr_out_nx;
      data_out   <= data_out_nx;
    end
  end

endmodule
